// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM with memory-ready handshake and access timeout.
// Optional BNE support is compiled in with `define MC_CONTROL_BNE_EN.
module mc_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       mem_err,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_ADDI  = 6'b001000;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] wait_cnt_r;
  logic        is_mem_s;
  logic        timeout_s;
  logic        branch_take_s;

  assign is_mem_s  = (state_r == FETCH) || (state_r == MEMRD) || (state_r == MEMWR);
  // A ready on the timeout cycle still completes the access normally.
  assign timeout_s = is_mem_s && !mem_ready && (wait_cnt_r == TIMEOUT_CNT);

`ifdef MC_CONTROL_BNE_EN
  logic is_bne_r;

  // Remember whether the branch being executed is BNE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_bne_r <= 1'b0;
    end else if (state_r == DECODE) begin
      is_bne_r <= (opcode == OP_BNE);
    end else begin
      is_bne_r <= is_bne_r;
    end
  end

  assign branch_take_s = is_bne_r ? ~zero : zero;
`else
  assign branch_take_s = zero;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wait counter: counts stalled cycles in a memory state, zero everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 16'd0;
    end else if (is_mem_s && !mem_ready && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= 16'd0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH: begin
        if (mem_ready) state_next_s = DECODE;
        else           state_next_s = FETCH;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_RTYPE:     state_next_s = EXEC;
          OP_BEQ:       state_next_s = BRANCH;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       state_next_s = BRANCH;
`endif
          OP_ADDI:      state_next_s = ADDIEX;
          OP_J:         state_next_s = JUMP;
          default:      state_next_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW) state_next_s = MEMRD;
        else                 state_next_s = MEMWR;
      end
      MEMRD: begin
        if (mem_ready)      state_next_s = MEMWB;
        else if (timeout_s) state_next_s = FETCH;
        else                state_next_s = MEMRD;
      end
      MEMWR: begin
        if (mem_ready)      state_next_s = FETCH;
        else if (timeout_s) state_next_s = FETCH;
        else                state_next_s = MEMWR;
      end
      EXEC:    state_next_s = ALUWB;
      ADDIEX:  state_next_s = ADDIWB;
      default: state_next_s = FETCH;
    endcase
  end

  // Output decode from the state register, with reset and timeout suppression.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;
    mem_err    = 1'b0;
    illegal_op = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:  illegal_op = 1'b0;
`endif
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = mem_ready;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCEn    = branch_take_s;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: mem_req = 1'b0;
    endcase
    if (rst) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSrc      = 2'b00;
      PCEn       = 1'b0;
      illegal_op = 1'b0;
    end else if (timeout_s) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      mem_err  = 1'b1;
    end else begin
      mem_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected output vectors are queued
// by each scenario and compared as the FSM steps.
module tb_mc_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, mem_err, illegal_op;
  logic [16:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .mem_err(mem_err), .illegal_op(illegal_op)
  );

  assign outs = {mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUOp, PCSrc, PCEn, mem_err, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ov(input logic mr, mw, iord, irw, rdst, m2r, rw, sa,
                                     input logic [1:0] srcb, op, pcs,
                                     input logic pce, me, ill);
    return {mr, mw, iord, irw, rdst, m2r, rw, sa, srcb, op, pcs, pce, me, ill};
  endfunction

  localparam logic [16:0] F_RDY   = ov(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
  localparam logic [16:0] F_WAIT  = ov(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
  localparam logic [16:0] F_TO    = ov(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,1,0);
  localparam logic [16:0] DEC     = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
  localparam logic [16:0] DEC_ILL = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,1);
  localparam logic [16:0] MEMADR  = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
  localparam logic [16:0] MEMRD   = ov(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [16:0] MEMRD_TO= ov(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0);
  localparam logic [16:0] MEMWB   = ov(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [16:0] MEMWR_R = ov(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [16:0] EXEC    = ov(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
  localparam logic [16:0] ALUWB   = ov(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [16:0] BR_T    = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0);
  localparam logic [16:0] BR_N    = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,0);
  localparam logic [16:0] ADDIEX  = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
  localparam logic [16:0] ADDIWB  = ov(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [16:0] JUMP    = ov(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BNE = 6'b000101, OP_BAD = 6'b111111;

  typedef struct {
    logic [5:0]  opc;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];

  task automatic push(input logic [5:0] opc, input logic z, input logic rdy,
                      input logic [16:0] exp, input string tag);
    item_t it;
    it.opc = opc; it.z = z; it.rdy = rdy; it.exp = exp; it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic test_reset;
    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
    #2;
    n_checks++;
    if (outs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 17'd0);
    end
    @(negedge clk);
    n_checks++;
    if (outs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", outs, 17'd0);
    end
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs !== F_WAIT) begin
      n_fail++;
      $display("FAIL reset_release_fetch: got %b expected %b", outs, F_WAIT);
    end
  endtask

  task automatic test_rtype;
    push(OP_R, 0, 1, F_RDY, "r_fetch");
    push(OP_R, 0, 0, DEC,   "r_decode");
    push(OP_R, 0, 1, EXEC,  "r_exec");
    push(OP_R, 0, 0, ALUWB, "r_aluwb");
    push(OP_ADDI, 0, 1, F_RDY,  "addi_fetch");
    push(OP_ADDI, 0, 1, DEC,    "addi_decode");
    push(OP_ADDI, 0, 1, ADDIEX, "addi_ex");
    push(OP_ADDI, 0, 1, ADDIWB, "addi_wb");
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      @(negedge clk);
      opcode = it.opc; zero = it.z; mem_ready = it.rdy;
      #1;
      n_checks++;
      if (outs !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.tag, outs, it.exp);
      end
    end
  endtask

  task automatic test_mem;
    push(OP_LW, 0, 1, F_RDY,  "lw_fetch");
    push(OP_LW, 0, 1, DEC,    "lw_decode");
    push(OP_LW, 0, 1, MEMADR, "lw_memadr");
    for (int i = 0; i < 3; i++) push(OP_LW, 0, 0, MEMRD, "lw_memrd_stall");
    push(OP_LW, 0, 1, MEMRD,  "lw_memrd_done");
    push(OP_LW, 0, 1, MEMWB,  "lw_memwb");
    push(OP_SW, 0, 1, F_RDY,  "sw_fetch");
    push(OP_SW, 0, 1, DEC,    "sw_decode");
    push(OP_SW, 0, 1, MEMADR, "sw_memadr");
    push(OP_SW, 0, 1, MEMWR_R,"sw_memwr");
    push(OP_J, 0, 1, F_RDY, "j_fetch");
    push(OP_J, 0, 1, DEC,   "j_decode");
    push(OP_J, 0, 1, JUMP,  "j_jump");
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      @(negedge clk);
      opcode = it.opc; zero = it.z; mem_ready = it.rdy;
      #1;
      n_checks++;
      if (outs !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.tag, outs, it.exp);
      end
    end
  endtask

  task automatic test_branch;
    push(OP_BEQ, 1, 1, F_RDY, "beq_t_fetch");
    push(OP_BEQ, 1, 1, DEC,   "beq_t_decode");
    push(OP_BEQ, 1, 1, BR_T,  "beq_taken");
    push(OP_BEQ, 0, 1, F_RDY, "beq_n_fetch");
    push(OP_BEQ, 0, 1, DEC,   "beq_n_decode");
    push(OP_BEQ, 0, 1, BR_N,  "beq_not_taken");
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      @(negedge clk);
      opcode = it.opc; zero = it.z; mem_ready = it.rdy;
      #1;
      n_checks++;
      if (outs !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.tag, outs, it.exp);
      end
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 4; i++) push(OP_J, 0, 0, F_WAIT, "to_fetch_wait");
    push(OP_J, 0, 0, F_TO, "to_fetch_err");
    for (int i = 0; i < 4; i++) push(OP_J, 0, 0, F_WAIT, "to_fetch_rewait");
    push(OP_J, 0, 1, F_RDY, "to_ready_priority");
    push(OP_J, 0, 1, DEC,   "to_j_decode");
    push(OP_J, 0, 1, JUMP,  "to_j_jump");
    push(OP_LW, 0, 1, F_RDY,  "to_lw_fetch");
    push(OP_LW, 0, 1, DEC,    "to_lw_decode");
    push(OP_LW, 0, 1, MEMADR, "to_lw_memadr");
    for (int i = 0; i < 4; i++) push(OP_LW, 0, 0, MEMRD, "to_memrd_wait");
    push(OP_LW, 0, 0, MEMRD_TO, "to_memrd_err");
    push(OP_LW, 0, 0, F_WAIT,   "to_memrd_back_fetch");
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      @(negedge clk);
      opcode = it.opc; zero = it.z; mem_ready = it.rdy;
      #1;
      n_checks++;
      if (outs !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.tag, outs, it.exp);
      end
    end
  endtask

  task automatic test_illegal;
    push(OP_BAD, 0, 1, F_RDY,   "ill_fetch");
    push(OP_BAD, 0, 1, DEC_ILL, "ill_decode");
    push(OP_BNE, 0, 1, F_RDY,   "bne_fetch");
`ifdef MC_CONTROL_BNE_EN
    push(OP_BNE, 0, 1, DEC,     "bne_decode");
    push(OP_BNE, 0, 1, BR_T,    "bne_taken");
    push(OP_BNE, 1, 1, F_RDY,   "bne2_fetch");
    push(OP_BNE, 1, 1, DEC,     "bne2_decode");
    push(OP_BNE, 1, 1, BR_N,    "bne_not_taken");
`else
    push(OP_BNE, 0, 1, DEC_ILL, "bne_illegal");
`endif
    push(OP_R, 0, 0, F_WAIT, "ill_back_fetch");
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      @(negedge clk);
      opcode = it.opc; zero = it.z; mem_ready = it.rdy;
      #1;
      n_checks++;
      if (outs !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.tag, outs, it.exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    push(OP_SW, 0, 1, F_RDY,  "rm_fetch");
    push(OP_SW, 0, 1, DEC,    "rm_decode");
    push(OP_SW, 0, 1, MEMADR, "rm_memadr");
    push(OP_SW, 0, 1, MEMWR_R,"rm_memwr");
    while (sb.size() > 0) begin
      item_t it = sb.pop_front();
      @(negedge clk);
      opcode = it.opc; zero = it.z; mem_ready = it.rdy;
      #1;
      n_checks++;
      if (outs !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.tag, outs, it.exp);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0 || outs !== 17'd0) begin
      n_fail++;
      $display("FAIL rm_async_clear: got %b expected %b", outs, 17'd0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs !== F_WAIT) begin
      n_fail++;
      $display("FAIL rm_fetch_after_release: got %b expected %b", outs, F_WAIT);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle MIPS main control FSM that sequences the shared ALU, register file, unified memory, IR and PC across fetch, decode, execute, memory and writeback steps.
- Drives the 2-bit ALUOp consumed by the existing ALU control decoder (00 = add, 01 = sub, 1x = decode funct).
- Waits on a memory ready handshake and aborts a stalled access after a programmable timeout.

Parameters:
- MEM_TIMEOUT, 255: max cycles to wait for mem_ready in any memory state; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  memory write enable
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRWrite  out  1  IR load enable
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2
- ALUOp  out  2  to ALU control decoder
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable (already qualified by branch)
- mem_err  out  1  one-cycle pulse on memory timeout
- illegal_op  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: asynchronous, active-high. State goes to FETCH and the wait counter to 0. While rst is high, every enable (mem_req, MemWrite, IRWrite, RegWrite, PCEn) and both pulses are 0. Mux selects are don't-care but driven to 0.
- Outputs are decoded combinationally from the state register. Enables in memory states are additionally qualified by mem_ready. Unlisted outputs are 0.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCEn=mem_ready. On mem_ready go to DECODE, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEMADR
  - 000000 -> EXEC
  - 000100 (BEQ) -> BRANCH
  - 001000 (ADDI) -> ADDIEX
  - 000010 (J) -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, IorD=1. On mem_ready go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=mem_ready. On mem_ready go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=zero. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- JUMP: PCSrc=10, PCEn=1. Go to FETCH.
- Wait counter (16-bit):
  - Cleared on entry to any memory state (FETCH, MEMRD, MEMWR).
  - Increments each cycle the FSM stays in a memory state with mem_ready=0.
  - When the count equals MEM_TIMEOUT and mem_ready=0: mem_err=1 for one cycle, go to FETCH with all enables 0, PC unchanged.
  - mem_ready=1 on the timeout cycle takes priority: normal completion, no mem_err.
- Reset mid-instruction discards the instruction; no partial writeback.
- Cycle counts with mem_ready tied high: R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3.

Optional Feature:
- Macro MC_CONTROL_BNE_EN.
- With it defined: opcode 000101 (BNE) in DECODE goes to the BRANCH state, and a registered is_bne flag (captured in DECODE) makes PCEn=~zero.
- Without it: 000101 is illegal, handled as above (illegal_op pulse, return to FETCH).

Test Plan:
- Reset, then mem_ready=1 and opcode=000000. Expect states FETCH, DECODE, EXEC, ALUWB, FETCH; ALUOp=10 in EXEC; RegWrite=1, RegDst=1 in ALUWB only.
- LW opcode=100011 with mem_ready low 3 cycles in MEMRD. Expect MEMRD held 4 cycles, mem_req=1 throughout, then MEMWB with MemtoReg=1, RegWrite=1; total 8 cycles.
- BEQ with zero=1, then zero=0. Expect PCEn=1, PCSrc=01, ALUOp=01 in BRANCH for the first; PCEn=0 for the second.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH. Expect mem_err pulse after 5 FETCH cycles, no IRWrite/PCEn, FETCH re-entered with the counter cleared.
- opcode=111111 in DECODE. Expect a one-cycle illegal_op pulse and return to FETCH. With MC_CONTROL_BNE_EN: opcode 000101 with zero=0 gives PCEn=1.
- Assert rst in MEMWR with mem_ready=1. Expect MemWrite=0 immediately (asynchronous), and the state is FETCH after rst is released.
